dma_w_burst_ctrl: RTL
=====================

Name: dma_w_burst_ctrl

Overview:
- Transfer sequencer in front of the AXI write DMA engine.
- Accepts one transfer descriptor: start byte address plus total word count.
- Splits the transfer into AXI INCR bursts of at most MAX_BURST beats and issues them to the engine one at a time.
- Moves data words from a source FIFO into the engine and signals completion to the host register block.

Parameters:
- ADDR_W, 32: byte address width.
- DMA_DATA_W, 32: data word width; BYTES = DMA_DATA_W/8.
- CNT_W, 16: width of the transfer word count.
- MAX_BURST, 256: maximum beats per burst; legal range 1..256.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_start  in  1  one-cycle pulse that starts a transfer.
- cfg_addr  in  ADDR_W  start byte address; low log2(BYTES) bits ignored (treated as 0).
- cfg_nwords  in  CNT_W  total words to write.
- cfg_busy  out  1  transfer in progress.
- cfg_done  out  1  one-cycle pulse when the transfer completes.
- src_level  in  CNT_W  words currently held in the source FIFO.
- src_wdata  in  DMA_DATA_W  head-of-FIFO data.
- src_wstrb  in  BYTES  head-of-FIFO strobes.
- src_rd  out  1  pop the source FIFO head.
- eng_valid  out  1  command/data valid to the engine.
- eng_addr  out  ADDR_W  burst start address.
- eng_len  out  8  AXI len, equal to beats-1.
- eng_wdata  out  DMA_DATA_W  equal to src_wdata.
- eng_wstrb  out  BYTES  equal to src_wstrb.
- eng_ready  in  1  engine accepted one data word.
- eng_dma_ready  in  1  engine idle in its address phase.

Behaviour:
- Reset values: cfg_busy=0, cfg_done=0, eng_valid=0, eng_addr=0, eng_len=0, src_rd=0, internal counters 0, state IDLE.
- Reset mid-operation:
  - Any state returns to IDLE on the next clk edge.
  - No cfg_done pulse is generated.
  - Partial-burst recovery in the engine is outside this block.
- Registers:
  - addr_r (ADDR_W), rem_r (CNT_W) and beats_r (9 bits, 1..256).
  - beat_cnt (9 bits).
- eng_addr = addr_r; eng_len = beats_r-1, truncated to 8 bits.
- src_rd = eng_ready while in DATA, else 0.
- eng_wdata and eng_wstrb are combinational pass-throughs.
- cfg_busy = (state != IDLE).
- State IDLE:
  - On cfg_start with cfg_nwords != 0: load addr_r and rem_r, then go to CALC.
  - On cfg_start with cfg_nwords == 0: pulse cfg_done on the next cycle and stay in IDLE.
  - cfg_start in any other state is ignored.
- State CALC (1 cycle):
  - beats_r = min(rem_r, MAX_BURST, boundary limit; see Optional Feature).
  - beat_cnt = 0.
  - Go to ISSUE.
- State ISSUE:
  - Wait for eng_dma_ready=1 and src_level >= beats_r.
  - Then assert eng_valid and go to DATA in the same cycle.
  - Guarantees the engine never pulls a word the FIFO does not hold.
- State DATA:
  - eng_valid held at 1.
  - Each eng_ready: beat_cnt+1.
  - When eng_ready arrives with beat_cnt == beats_r-1:
    - eng_valid drops on the next cycle.
    - addr_r += beats_r*BYTES, wrapping modulo 2^ADDR_W.
    - rem_r -= beats_r.
    - Go to WAIT.
- State WAIT:
  - Wait for eng_dma_ready=1, which the engine raises only after its write response.
  - If rem_r == 0: pulse cfg_done and go to IDLE.
  - Otherwise go to CALC.
- Latency:
  - cfg_start to first eng_valid: 2 cycles minimum (IDLE→CALC→ISSUE).
  - Each inter-burst gap: at least 2 cycles (WAIT→CALC→ISSUE).
- eng_ready outside DATA is ignored; no counter changes.
- eng_addr and eng_len are stable for the whole time eng_valid is high.

Optional Feature:
- Macro DMA_W_BURST_4K_SPLIT_EN.
- Defined:
  - Boundary limit = (4096 - addr_r[11:0]) >> log2(BYTES), computed in 13 bits.
  - No burst crosses a 4 KB address boundary (AXI rule).
- Undefined:
  - Boundary limit is not applied; beats_r = min(rem_r, MAX_BURST).
  - The system integrator guarantees boundary-safe descriptors.

Test Plan:
- Single burst: addr=0x1000, nwords=10, src_level=64.
  - One burst with eng_addr=0x1000, eng_len=9.
  - 10 src_rd pulses.
  - cfg_done 1 cycle after eng_dma_ready returns; cfg_busy low the following cycle.
- Multi-burst: addr=0x0, nwords=600, MAX_BURST=256, FIFO full.
  - Bursts (0x000, len 255), (0x400, len 255), (0x800, len 87).
  - Exactly 600 src_rd pulses and one cfg_done.
- 4 KB split: addr=0x0FF0, nwords=8.
  - Macro on: bursts (0x0FF0, len 3) then (0x1000, len 3).
  - Macro off: single burst (0x0FF0, len 7).
- FIFO starvation: nwords=5, src_level=3.
  - eng_valid stays 0 for 20 cycles.
  - Raise src_level to 5: eng_valid asserts the same cycle, and the burst completes with eng_len=4.
- Zero length and start-while-busy:
  - nwords=0: cfg_done pulses 1 cycle later; cfg_busy and eng_valid never assert.
  - Second cfg_start during DATA: ignored, word count unchanged.
- Reset mid-DATA: assert rst after 3 of 16 beats.
  - Next cycle: eng_valid=0, cfg_busy=0, no cfg_done.
  - A new cfg_start after reset runs normally.

Source files
------------

// File: rtl/dma_w_burst_ctrl.sv
// rtl/dma_w_burst_ctrl.sv - splits one write descriptor into AXI INCR bursts and feeds the DMA engine
// Optional 4 KB boundary splitting is enabled by defining DMA_W_BURST_4K_SPLIT_EN.
module dma_w_burst_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DMA_DATA_W = 32,
  parameter int CNT_W      = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cfg_start,
  input  logic [ADDR_W-1:0]       cfg_addr,
  input  logic [CNT_W-1:0]        cfg_nwords,
  output logic                    cfg_busy,
  output logic                    cfg_done,
  input  logic [CNT_W-1:0]        src_level,
  input  logic [DMA_DATA_W-1:0]   src_wdata,
  input  logic [DMA_DATA_W/8-1:0] src_wstrb,
  output logic                    src_rd,
  output logic                    eng_valid,
  output logic [ADDR_W-1:0]       eng_addr,
  output logic [7:0]              eng_len,
  output logic [DMA_DATA_W-1:0]   eng_wdata,
  output logic [DMA_DATA_W/8-1:0] eng_wstrb,
  input  logic                    eng_ready,
  input  logic                    eng_dma_ready
);
  localparam int BYTES   = DMA_DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BYTES - 1);
  localparam logic [8:0]        MAX_B9    = 9'(MAX_BURST);
  localparam logic [CNT_W-1:0]  MAX_BC    = CNT_W'(MAX_BURST);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_ISSUE = 3'd2,
    S_DATA  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [8:0]        beats_q, beats_d;
  logic [8:0]        beat_cnt_q, beat_cnt_d;
  logic [7:0]        eng_len_q, eng_len_d;
  logic              done_q, done_d;
  logic [8:0]        rem_cap;
  logic [8:0]        beats_calc;
  logic              issue_go;
  logic              last_beat;
`ifdef DMA_W_BURST_4K_SPLIT_EN
  logic [12:0]       room_4k;
`endif

  always_comb begin
    rem_cap = (rem_q > MAX_BC) ? MAX_B9 : rem_q[8:0];
`ifdef DMA_W_BURST_4K_SPLIT_EN
    // Words left before the next 4 KB page; never zero because addr_q is word aligned.
    room_4k    = (13'd4096 - {1'b0, addr_q[11:0]}) >> BYTE_SH;
    beats_calc = ({4'd0, rem_cap} > room_4k) ? room_4k[8:0] : rem_cap;
`else
    beats_calc = rem_cap;
`endif
  end

  // The command goes out in the cycle the engine is idle and the FIFO already holds the whole burst.
  assign issue_go  = (state_q == S_ISSUE) && eng_dma_ready && (src_level >= CNT_W'(beats_q));
  assign last_beat = (state_q == S_DATA) && eng_ready && (beat_cnt_q == beats_q - 9'd1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beats_d    = beats_q;
    beat_cnt_d = beat_cnt_q;
    eng_len_d  = eng_len_q;
    done_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          if (cfg_nwords != '0) begin
            addr_d  = cfg_addr & ADDR_MASK;
            rem_d   = cfg_nwords;
            state_d = S_CALC;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_CALC: begin
        beats_d    = beats_calc;
        eng_len_d  = 8'(beats_calc - 9'd1);
        beat_cnt_d = '0;
        state_d    = S_ISSUE;
      end
      S_ISSUE: begin
        if (issue_go) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (eng_ready) begin
          beat_cnt_d = beat_cnt_q + 9'd1;
          if (last_beat) begin
            addr_d  = addr_q + (ADDR_W'(beats_q) << BYTE_SH);
            rem_d   = rem_q - CNT_W'(beats_q);
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (eng_dma_ready) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      beats_q    <= '0;
      beat_cnt_q <= '0;
      eng_len_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beats_q    <= beats_d;
      beat_cnt_q <= beat_cnt_d;
      eng_len_q  <= eng_len_d;
      done_q     <= done_d;
    end
  end

  assign cfg_busy  = (state_q != S_IDLE);
  assign cfg_done  = done_q;
  assign eng_valid = (state_q == S_DATA) || issue_go;
  assign eng_addr  = addr_q;
  assign eng_len   = eng_len_q;
  assign src_rd    = (state_q == S_DATA) && eng_ready;
  assign eng_wdata = src_wdata;
  assign eng_wstrb = src_wstrb;

endmodule
